// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: shared tick prescaler plus per-channel OFF/ON/BLINK/ONESHOT control.
// Define LED_ACTIVE_LOW_EN to invert the led port for current-sinking LEDs.
module led_blink_multi #(
    parameter int unsigned CLK_HZ   = 25000000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half_period,
    output logic                tick,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] led
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [CHANNELS-1:0] LED_POL = '1;
`else
    localparam logic [CHANNELS-1:0] LED_POL = '0;
`endif

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    logic [PRE_W-1:0]    pre, pre_n;
    logic                tick_n;
    logic                ready_n;
    logic                accept;
    mode_t               mode   [CHANNELS];
    mode_t               mode_n [CHANNELS];
    logic [PERIOD_W-1:0] cnt    [CHANNELS];
    logic [PERIOD_W-1:0] cnt_n  [CHANNELS];
    logic [PERIOD_W-1:0] hp     [CHANNELS];
    logic [PERIOD_W-1:0] hp_n   [CHANNELS];
    logic [CHANNELS-1:0] lit, lit_n;
    logic [CHANNELS-1:0] busy_n;

    // Logical LED state; the port register holds it with the board polarity applied.
    assign lit = led ^ LED_POL;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre       <= '0;
            tick      <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= '0;
            led       <= LED_POL;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                mode[i] <= MODE_OFF;
                cnt[i]  <= '0;
                hp[i]   <= '0;
            end
        end else begin
            pre       <= pre_n;
            tick      <= tick_n;
            cfg_ready <= ready_n;
            busy      <= busy_n;
            led       <= lit_n ^ LED_POL;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                mode[i] <= mode_n[i];
                cnt[i]  <= cnt_n[i];
                hp[i]   <= hp_n[i];
            end
        end
    end

    // Next-state: prescaler, handshake and per-channel sequencing
    always_comb begin
        accept  = cfg_valid && cfg_ready;
        pre_n   = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
        tick_n  = (pre == PRE_LAST);
        ready_n = !accept;
        lit_n   = lit;
        busy_n  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            mode_n[i] = mode[i];
            cnt_n[i]  = cnt[i];
            hp_n[i]   = hp[i];
            // A config write to this channel overrides a coincident tick.
            if (accept && (cfg_ch == 4'(i))) begin
                mode_n[i] = mode_t'(cfg_mode);
                cnt_n[i]  = '0;
                hp_n[i]   = (cfg_half_period == '0) ? ONE : cfg_half_period;
                lit_n[i]  = (mode_t'(cfg_mode) != MODE_OFF);
            end else if (tick) begin
                case (mode[i])
                    MODE_BLINK: begin
                        if (cnt[i] == hp[i] - ONE) begin
                            lit_n[i] = !lit[i];
                            cnt_n[i] = '0;
                        end else begin
                            cnt_n[i] = cnt[i] + ONE;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt[i] == hp[i] - ONE) begin
                            lit_n[i]  = 1'b0;
                            mode_n[i] = MODE_OFF;
                            cnt_n[i]  = '0;
                        end else begin
                            cnt_n[i] = cnt[i] + ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            busy_n[i] = (mode_n[i] == MODE_BLINK) || (mode_n[i] == MODE_ONESHOT);
        end
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Randomised self-checking bench for led_blink_multi with a tick-counting reference model.
// Honours LED_ACTIVE_LOW_EN for the expected led polarity.
module tb_led_blink_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned PW = 4;
    localparam int DIVI = 4;
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [CH-1:0] POL = '1;
`else
    localparam logic [CH-1:0] POL = '0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [3:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PW-1:0] cfg_half_period = '0;
    logic          tick;
    logic [CH-1:0] busy;
    logic [CH-1:0] led;
    logic [CH-1:0] lit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign lit = led ^ POL;

    led_blink_multi #(
        .CLK_HZ(8), .TICK_HZ(2), .CHANNELS(CH), .PERIOD_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
        .tick(tick), .busy(busy), .led(led)
    );

    // Reference model: m_n counts ticks seen since the channel was configured.
    int   m_cyc;
    logic m_ready;
    int   m_mode [CH];
    int   m_hp   [CH];
    int   m_n    [CH];

    function automatic logic exp_tick();
        return (m_cyc > 0) && ((m_cyc % DIVI) == 0);
    endfunction

    function automatic logic [CH-1:0] exp_led();
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < int'(CH); i++) begin
            case (m_mode[i])
                1:       v[i] = 1'b1;
                2:       v[i] = (m_hp[i] > 0) && (((m_n[i] / m_hp[i]) % 2) == 0);
                3:       v[i] = 1'b1;
                default: v[i] = 1'b0;
            endcase
        end
        return v ^ POL;
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        logic [CH-1:0] v;
        for (int i = 0; i < int'(CH); i++) v[i] = (m_mode[i] >= 2);
        return v;
    endfunction

    function automatic logic [2*CH+1:0] exp_vec();
        return {exp_led(), exp_busy(), exp_tick(), m_ready};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cyc   <= 0;
            m_ready <= 1'b0;
            for (int i = 0; i < int'(CH); i++) begin
                m_mode[i] <= 0;
                m_hp[i]   <= 0;
                m_n[i]    <= 0;
            end
        end else begin
            m_cyc   <= m_cyc + 1;
            m_ready <= !(cfg_valid && m_ready);
            for (int i = 0; i < int'(CH); i++) begin
                if (cfg_valid && m_ready && (int'(cfg_ch) == i)) begin
                    m_mode[i] <= int'(cfg_mode);
                    m_hp[i]   <= (cfg_half_period == '0) ? 1 : int'(cfg_half_period);
                    m_n[i]    <= 0;
                end else if (exp_tick() && m_mode[i] == 2) begin
                    m_n[i] <= m_n[i] + 1;
                end else if (exp_tick() && m_mode[i] == 3) begin
                    if (m_n[i] + 1 >= m_hp[i]) begin
                        m_mode[i] <= 0;
                        m_n[i]    <= 0;
                    end else begin
                        m_n[i] <= m_n[i] + 1;
                    end
                end
            end
        end
    end

    // Issue one config write from a negedge; returns at the negedge after acceptance.
    task automatic wr(input logic [3:0] ch, input logic [1:0] mode, input logic [PW-1:0] hp);
        bit done;
        done = 1'b0;
        cfg_ch = ch;
        cfg_mode = mode;
        cfg_half_period = hp;
        cfg_valid = 1'b1;
        for (int w = 0; w < 8 && !done; w++) begin
            if (cfg_ready) done = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wr_accept ch=%0d: got no acceptance, required acceptance within 8 clocks", ch);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({led, busy, tick, cfg_ready} !== {POL, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", {led, busy, tick, cfg_ready}, {POL, 6'b0});
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL tick_after_release k=%0d: got %b required %b", k, tick, (k % 4) == 0);
            end
            checks++;
            if (cfg_ready !== 1'b1 && k == 1) begin
                errors++;
                $display("FAIL ready_after_release: got %b required 1", cfg_ready);
            end else if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
        end
    endtask

    task automatic test_blink();
        int toggles;
        logic prev;
        wr(4'd0, 2'd2, 4'd3);
        checks++;
        if ({lit[0], busy[0], cfg_ready} !== 3'b110) begin
            errors++;
            $display("FAIL blink_start: got %b required 110", {lit[0], busy[0], cfg_ready});
        end
        toggles = 0;
        prev = led[0];
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (led[0] !== prev) toggles++;
            prev = led[0];
            checks++;
            if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL blink_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
        end
        checks++;
        if (toggles != 4) begin
            errors++;
            $display("FAIL blink_toggles: got %0d required 4", toggles);
        end
    endtask

    task automatic test_oneshot();
        wr(4'd2, 2'd3, 4'd2);
        checks++;
        if ({lit[2], busy[2]} !== 2'b11) begin
            errors++;
            $display("FAIL oneshot_start: got %b required 11", {lit[2], busy[2]});
        end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            checks++;
            if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL oneshot_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
        end
        checks++;
        if ({lit[2], busy[2]} !== 2'b00) begin
            errors++;
            $display("FAIL oneshot_done: got %b required 00", {lit[2], busy[2]});
        end
        wr(4'd1, 2'd1, 4'd5);
        for (int k = 0; k < 8; k++) @(negedge clk);
        checks++;
        if ({lit[1], busy[1]} !== 2'b10) begin
            errors++;
            $display("FAIL on_steady: got %b required 10", {lit[1], busy[1]});
        end
    endtask

    task automatic test_tick_collision();
        bit found;
        logic prev3;
        wr(4'd3, 2'd2, 4'd1);
        wr(4'd0, 2'd2, 4'd2);
        found = 1'b0;
        for (int w = 0; w < 16 && !found; w++) begin
            if (exp_tick() && cfg_ready) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL collision_align: got no tick with ready, required one within 16 clocks");
        end
        prev3 = lit[3];
        cfg_ch = 4'd0;
        cfg_mode = 2'd2;
        cfg_half_period = 4'd2;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ({lit[0], lit[3]} !== {1'b1, !prev3}) begin
            errors++;
            $display("FAIL collision_edge: got %b required %b", {lit[0], lit[3]}, {1'b1, !prev3});
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL collision_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
            if (k == 4 || k == 8) begin
                checks++;
                if (lit[0] !== (k == 4)) begin
                    errors++;
                    $display("FAIL collision_ch0 k=%0d: got %b required %b", k, lit[0], k == 4);
                end
            end
        end
    endtask

    task automatic test_bad_channel();
        logic [CH-1:0] led_s, busy_s;
        int toggles;
        logic prev;
        wr(4'd0, 2'd0, 4'd1);
        wr(4'd3, 2'd0, 4'd1);
        led_s = led;
        busy_s = busy;
        wr(4'd7, 2'd1, 4'd3);
        checks++;
        if ({led, busy, cfg_ready} !== {led_s, busy_s, 1'b0}) begin
            errors++;
            $display("FAIL bad_channel: got %b required %b", {led, busy, cfg_ready}, {led_s, busy_s, 1'b0});
        end
        wr(4'd1, 2'd2, 4'd0);
        toggles = 0;
        prev = led[1];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led[1] !== prev) toggles++;
            prev = led[1];
            checks++;
            if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL hp0_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
        end
        checks++;
        if (toggles != 4) begin
            errors++;
            $display("FAIL hp0_toggles: got %0d required 4", toggles);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cfg_ch = 4'($urandom_range(0, 7));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_half_period = PW'($urandom_range(0, 5));
        cfg_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (cfg_ready !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_ready k=%0d: got %b required %b", k, cfg_ready, (k % 2) == 0);
            end
            @(negedge clk);
            checks++;
            if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
            if ((k % 2) == 0) begin
                cfg_ch = 4'($urandom_range(0, 7));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_half_period = PW'($urandom_range(0, 5));
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_random();
        logic acc;
        for (int k = 0; k < 400; k++) begin
            acc = cfg_valid && cfg_ready;
            @(negedge clk);
            checks++;
            if ({led, busy, tick, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL random_vec k=%0d: got %b required %b", k, {led, busy, tick, cfg_ready}, exp_vec());
            end
            if (acc) cfg_valid = 1'b0;
            if (!cfg_valid && $urandom_range(0, 3) == 0) begin
                cfg_ch = 4'($urandom_range(0, 7));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_half_period = ($urandom_range(0, 7) == 0) ? PW'(15) : PW'($urandom_range(0, 4));
                cfg_valid = 1'b1;
            end
        end
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        wr(4'd0, 2'd2, 4'd1);
        wr(4'd2, 2'd1, 4'd1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({led, busy, tick, cfg_ready} !== {POL, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got %b required %b", {led, busy, tick, cfg_ready}, {POL, 6'b0});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({led, busy, tick, cfg_ready} !== {POL, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_release: got %b required %b", {led, busy, tick, cfg_ready}, {POL, 5'b0, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_oneshot();
        test_tick_collision();
        test_bad_channel();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_blink_multi.md
Name: led_blink_multi

Overview:
Multi-channel LED blinker for the Colorlight 5A-75E, running from the 25 MHz board clock. It is the parametrised successor of the single-output blink top. A shared prescaler generates a slow tick. Each channel has its own mode and half-period, loaded through a valid/ready config port, and drives one LED pin directly from a register.

Parameters:
CLK_HZ, 25000000, input clock frequency in Hz
TICK_HZ, 1000, prescaler tick rate in Hz; tick period = CLK_HZ/TICK_HZ clocks (integer, >= 2)
CHANNELS, 4, number of LED channels (1..16)
PERIOD_W, 16, width of per-channel half-period, in ticks

Ports:
clk  input  1  system clock, 25 MHz
rst  input  1  synchronous reset, active-high
cfg_valid  input  1  config write request
cfg_ready  output  1  block can accept a config write
cfg_ch  input  4  target channel index
cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT
cfg_half_period  input  PERIOD_W  half-period in ticks
tick  output  1  one-clock pulse at each prescaler wrap
busy  output  CHANNELS  per-channel flag: 1 while in BLINK or ONESHOT
led  output  CHANNELS  LED drive, active-high; registered

Behaviour:
- Only clk and rst are used; all flops update on the rising edge of clk.
- While rst=1:
  - Prescaler is 0. All channel modes are OFF; all counters and half-periods are 0.
  - led=0, busy=0, tick=0, cfg_ready=0.
- First clock after reset release: cfg_ready=1.
- Prescaler counts 0..CLK_HZ/TICK_HZ-1 and wraps to 0. tick=1 for exactly the one clock in which the count equals its terminal value.
  - The first tick occurs CLK_HZ/TICK_HZ clocks after reset release.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready are both high at a clock edge.
  - cfg_ready drops to 0 for the single following clock, then returns to 1. Back-to-back writes therefore take 2 clocks each.
  - cfg_valid held high while cfg_ready=0 is not accepted. The source must hold cfg_valid and the cfg_* fields stable until acceptance.
  - cfg_ch >= CHANNELS: the write is accepted (handshake completes) but no state changes.
- On accept (state visible the next clock):
  - The selected channel's counter is cleared and mode/half-period are stored.
  - A cfg_half_period of 0 is stored as 1.
  - led[ch]: OFF gives 0; ON, BLINK and ONESHOT give 1.
- Per-channel behaviour on tick:
  - OFF and ON: no change.
  - BLINK: counter increments. When counter == half_period-1, led toggles and counter returns to 0. The result is a square wave of period 2*half_period ticks that starts in the on phase.
  - ONESHOT: counter increments. When counter == half_period-1, led goes to 0, mode becomes OFF and busy drops, all in the same clock. The pulse lasts half_period ticks, with up to 1 tick of uncertainty at the start.
- Simultaneous events:
  - A config write to channel k in the same clock as tick: the config wins and the tick is ignored for channel k only.
  - Other channels process that tick normally.
- Rewriting a running channel restarts it from counter 0 in the new mode.
- Widths:
  - Counter is PERIOD_W bits.
  - Compare uses half_period-1, so half_period = 2^PERIOD_W-1 is the maximum usable value and must not overflow.
  - Prescaler width is clog2(CLK_HZ/TICK_HZ).
- busy[ch] = 1 exactly when the mode is BLINK or ONESHOT; it is registered and aligned with led.
- Reset mid-operation (rst asserted at any time) returns everything to the reset state on the next edge.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: the led port is the bitwise inverse of the internal LED state.
  - Reset value of led is all ones.
  - OFF drives 1 and ON drives 0.
  - Used for boards whose LEDs sink current.
- Not defined: led equals the internal state, reset value all zeros.
- All other outputs are unaffected either way.

Test Plan:
- Settings for every scenario: CLK_HZ=8, TICK_HZ=2 (tick every 4 clocks), CHANNELS=4, PERIOD_W=4.
- Reset then release: led=0000, busy=0000, and cfg_ready=1 one clock after release. First tick pulse arrives 4 clocks after release, repeating every 4 clocks.
- Write ch0 BLINK half_period=3: led[0]=1 the next clock, then toggles every 3 ticks (12 clocks). busy[0]=1. cfg_ready is 0 for 1 clock after acceptance.
- Write ch2 ONESHOT half_period=2, then after completion write ch1 ON: led[2] high for 2 ticks, then 0, mode OFF, busy[2]=0. led[1]=1 steady with busy[1]=0.
- Config write to ch0 in the tick clock while ch3 is BLINK half_period=1: ch0 counter is 0 after the write. ch3 toggles on that same tick.
- Write cfg_ch=7 with mode ON: handshake completes, led and busy unchanged. Write half_period=0 BLINK to ch1: led[1] toggles every tick.
- Assert rst mid-blink: all outputs return to reset values on the next edge. Rebuild with LED_ACTIVE_LOW_EN: after reset led=1111, and an ON channel drives 0.
